// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bus for if_id_stage: fetch handshake, flush, decode handshake and decoded fields.
// stall_cnt exists only when IFID_STALL_CNT_EN is defined.
interface if_id_stage_if #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   pc_plus4;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic [25:0]       target26;
`ifdef IFID_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    // Stage side.
    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, pc_plus4, opcode, rs, rt, rd, shamt, funct, imm16, target26
`ifdef IFID_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    // Fetch/decode environment side.
    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, pc_plus4, opcode, rs, rt, rd, shamt, funct, imm16, target26
`ifdef IFID_STALL_CNT_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: 2-entry skid buffer (main + skid) with flush and MIPS field split.
// Optional stall counter enabled by defining IFID_STALL_CNT_EN.
module if_id_stage #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    if_id_stage_if.slave   io_bus
);
    logic              r_main_valid;
    logic [INST_W-1:0] r_main_inst;
    logic [PC_W-1:0]   r_main_pc;
    logic              r_skid_valid;
    logic [INST_W-1:0] r_skid_inst;
    logic [PC_W-1:0]   r_skid_pc;

    logic w_in_ready;
    logic w_accept;
    logic w_consume;

    // Ready depends only on held state, so out_ready never reaches in_ready combinationally.
    assign w_in_ready = !r_skid_valid;
    assign w_accept   = io_bus.in_valid && w_in_ready;
    assign w_consume  = r_main_valid && io_bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_inst  <= '0;
            r_main_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= '0;
            r_skid_pc    <= '0;
        end else if (io_bus.flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            // FULL: no accept is possible, only drain skid into main.
            if (w_consume) begin
                r_main_inst  <= r_skid_inst;
                r_main_pc    <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid || w_consume) begin
                r_main_valid <= 1'b1;
                r_main_inst  <= io_bus.in_inst;
                r_main_pc    <= io_bus.in_pc;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_inst  <= io_bus.in_inst;
                r_skid_pc    <= io_bus.in_pc;
            end
        end else if (w_consume) begin
            r_main_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_main_valid;
    assign io_bus.pc_plus4  = r_main_pc + PC_W'(4);
    assign io_bus.opcode    = r_main_inst[31:26];
    assign io_bus.rs        = r_main_inst[25:21];
    assign io_bus.rt        = r_main_inst[20:16];
    assign io_bus.rd        = r_main_inst[15:11];
    assign io_bus.shamt     = r_main_inst[10:6];
    assign io_bus.funct     = r_main_inst[5:0];
    assign io_bus.imm16     = r_main_inst[15:0];
    assign io_bus.target26  = r_main_inst[25:0];

`ifdef IFID_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Counts cycles a valid output is held back; survives flush, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !io_bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign io_bus.stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: driver pushes expected words, negedge monitor checks outputs.
module tb_if_id_stage;
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n_out;
    bit   mon_en;
    exp_t q[$];

    if_id_stage_if #(.INST_W(32), .PC_W(32)) bus ();

    if_id_stage #(.INST_W(32), .PC_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue mirrors buffer contents; head is what the main entry must show.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
            if (bus.out_valid && q.size() != 0) begin
                check("opcode", {26'd0, bus.opcode}, {26'd0, q[0].inst[31:26]});
                check("rs", {27'd0, bus.rs}, {27'd0, q[0].inst[25:21]});
                check("rt", {27'd0, bus.rt}, {27'd0, q[0].inst[20:16]});
                check("rd", {27'd0, bus.rd}, {27'd0, q[0].inst[15:11]});
                check("shamt", {27'd0, bus.shamt}, {27'd0, q[0].inst[10:6]});
                check("funct", {26'd0, bus.funct}, {26'd0, q[0].inst[5:0]});
                check("imm16", {16'd0, bus.imm16}, {16'd0, q[0].inst[15:0]});
                check("target26", {6'd0, bus.target26}, {6'd0, q[0].inst[25:0]});
                check("pc_plus4", bus.pc_plus4, q[0].pc4);
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
    end

    // Entered just after a rising edge; returns just after the next one.
    task automatic step(input bit rst, input bit v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] pc4, input bit rdy, input bit fl);
        exp_t e;
        bit   acc;
        rst_n         = rst;
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
        @(negedge clk);
        acc = v && bus.in_ready;
        @(posedge clk);
        if (!rst || fl) begin
            q.delete();
        end else if (acc) begin
            e.inst = inst;
            e.pc4  = pc4;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    logic [31:0] stream_inst [8];
    logic [31:0] stream_pc   [8];
    logic [31:0] stream_pc4  [8];
    logic [31:0] sext;
    int          base;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_out    = 0;
        mon_en   = 1'b0;
        stream_inst = '{32'h00000000, 32'h012A4020, 32'h8D090008, 32'hAD0A000C,
                        32'h1109FFFE, 32'h08100004, 32'h000A4880, 32'hFFFFFFFF};
        stream_pc   = '{32'h00001000, 32'h00001004, 32'h00001008, 32'h0000100C,
                        32'h00001010, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h7FFFFFFC};
        stream_pc4  = '{32'h00001004, 32'h00001008, 32'h0000100C, 32'h00001010,
                        32'h00001014, 32'hFFFFFFFC, 32'h00000000, 32'h80000000};

        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset_pc_plus4", bus.pc_plus4, 32'h4);
        mon_en = 1'b1;

        // 1: single accept, addi $t0,$t1,-1
        step(1'b1, 1'b1, 32'h2128FFFF, 32'h00400000, 32'h00400004, 1'b1, 1'b0);
        check("t1_opcode", {26'd0, bus.opcode}, 32'h08);
        check("t1_rs", {27'd0, bus.rs}, 32'd9);
        check("t1_rt", {27'd0, bus.rt}, 32'd8);
        check("t1_imm16", {16'd0, bus.imm16}, 32'hFFFF);
        check("t1_pc_plus4", bus.pc_plus4, 32'h00400004);
        sext = {{16{bus.imm16[15]}}, bus.imm16};
        check("t1_sign_ext", sext, 32'hFFFFFFFF);
        idle(1'b1);

        // 2: backpressure fills skid, then drains in order
        step(1'b1, 1'b1, 32'h20087FFF, 32'h00400004, 32'h00400008, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h20088000, 32'h00400008, 32'h0040000C, 1'b0, 1'b0);
        check("t2_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
        check("t2_hold_imm", {16'd0, bus.imm16}, 32'h7FFF);
        idle(1'b0);
        check("t2_still_imm", {16'd0, bus.imm16}, 32'h7FFF);
        idle(1'b1);
        check("t2_second_imm", {16'd0, bus.imm16}, 32'h8000);
        check("t2_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        idle(1'b1);

        // 3: flush from FULL with an offered word
        step(1'b1, 1'b1, 32'h2008AAAA, 32'h0040000C, 32'h00400010, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h2008BBBB, 32'h00400010, 32'h00400014, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h20084000, 32'h00400014, 32'h00400018, 1'b0, 1'b1);
        check("t3_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t3_in_ready", {31'd0, bus.in_ready}, 32'd1);
        idle(1'b1);
        idle(1'b1);
        // flush with a consume in the same cycle
        step(1'b1, 1'b1, 32'h01095020, 32'h00400100, 32'h00400104, 1'b0, 1'b0);
        base = n_out;
        step(1'b1, 1'b1, 32'h2008CCCC, 32'h00400104, 32'h00400108, 1'b1, 1'b1);
        check("t3_flush_consume", n_out - base, 32'd1);
        check("t3b_out_valid", {31'd0, bus.out_valid}, 32'd0);
        idle(1'b1);

        // 4: reset while FULL and stalled
        step(1'b1, 1'b1, 32'h8D280004, 32'h00400200, 32'h00400204, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3C011001, 32'h00400204, 32'h00400208, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h2008DDDD, 32'h00400208, 32'h0040020C, 1'b0, 1'b0);
        check("t4_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t4_imm16", {16'd0, bus.imm16}, 32'd0);
        check("t4_opcode", {26'd0, bus.opcode}, 32'd0);
        check("t4_pc_plus4", bus.pc_plus4, 32'h4);
`ifdef IFID_STALL_CNT_EN
        check("t4_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
`endif

        // 5: full-rate stream with PC wrap
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, stream_inst[i], stream_pc[i], stream_pc4[i], 1'b1, 1'b0);
            if (i == 6) check("t5_wrap_pc4", bus.pc_plus4, 32'h0);
        end
        idle(1'b1);
        check("t5_out_count", n_out - base, 32'd8);
        check("t5_drained", {31'd0, bus.out_valid}, 32'd0);

`ifdef IFID_STALL_CNT_EN
        // 6: stall counter counts held cycles and saturates
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h2008EEEE, 32'h00400300, 32'h00400304, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        check("t6_stall_cnt_5", {16'd0, bus.stall_cnt}, 32'd5);
        for (int i = 0; i < 65535; i++) idle(1'b0);
        check("t6_stall_cnt_sat", {16'd0, bus.stall_cnt}, 32'hFFFF);
        idle(1'b1);
        check("t6_stall_cnt_kept", {16'd0, bus.stall_cnt}, 32'hFFFF);
`endif

        idle(1'b1);
        check("final_queue_empty", q.size(), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Instruction fetch/decode pipeline register for the MIPS datapath. It accepts a fetched instruction word and its PC from instruction memory over a valid/ready handshake and buffers it in a 2-entry skid buffer. It splits the word into fields: imm16 drives signExtend.seIn directly, and the other fields feed control, register file and jump logic. It supports downstream stall (backpressure) and a branch/jump flush.

Parameters:
INST_W, 32, instruction word width (fixed MIPS encoding; do not change)
PC_W, 32, program counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active low, sampled on rising clk
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage can accept this cycle
in_inst  input  INST_W  fetched instruction word
in_pc  input  PC_W  PC of in_inst
flush  input  1  discard all held and incoming instructions
out_valid  output  1  decoded instruction available
out_ready  input  1  decode/execute consumes this cycle
pc_plus4  output  PC_W  held PC + 4, wraps mod 2^PC_W
opcode  output  6  inst[31:26]
rs  output  5  inst[25:21]
rt  output  5  inst[20:16]
rd  output  5  inst[15:11]
shamt  output  5  inst[10:6]
funct  output  6  inst[5:0]
imm16  output  16  inst[15:0], to signExtend seIn
target26  output  26  inst[25:0], jump target

Behaviour:
- Storage: main entry (valid, inst, pc) drives all outputs; skid entry (valid, inst, pc) is hidden.
- All field outputs are combinational slices of the main entry. pc_plus4 is main pc + 4.
- in_ready = !skid_valid. It is a registered-state function only and has no combinational path from out_ready.
- Accept = in_valid && in_ready. Consume = out_valid && out_ready.
- States and transitions, evaluated at the rising edge:
  - EMPTY (main 0, skid 0):
    - accept -> ONE, loading main.
  - ONE (main 1, skid 0):
    - accept && consume -> ONE, main reloaded.
    - accept && !consume -> FULL, incoming word goes to skid.
    - !accept && consume -> EMPTY.
  - FULL (main 1, skid 1), with in_ready = 0:
    - consume -> ONE, skid moves to main.
- Latency: an accepted instruction appears on outputs the cycle after acceptance if the stage was EMPTY, or if the stage was ONE and the main entry is consumed in the same cycle.
- Order is strictly FIFO. No instruction is duplicated or dropped except by flush or reset.
- out_valid = main_valid. Outputs are held stable while out_valid && !out_ready.
- flush: at the next edge both valids clear (-> EMPTY).
  - Flush wins over a simultaneous accept: the instruction offered in the flush cycle is discarded.
  - A consume in the flush cycle still counts downstream.
- Reset, taken at a rising edge while rst_n = 0, applies even mid-transfer:
  - Both valids clear and all inst/pc registers clear to 0, so out_valid = 0 and every field output = 0.
  - pc_plus4 = 4.
  - in_ready = 1.
- Reset has priority over flush and over the handshake.
- Wrap-around: in_pc = 0xFFFF_FFFC gives pc_plus4 = 0x0000_0000.

Optional Feature:
Macro IFID_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0].
  - Increments on each cycle with out_valid && !out_ready.
  - Saturates at 0xFFFF.
  - Clears on reset.
  - Not cleared by flush.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Test Plan:
1. Reset release, then accept in_inst=0x2128FFFF, in_pc=0x0040_0000 with out_ready=1 -> next cycle:
   - out_valid=1, opcode=0x08, rs=9, rt=8, imm16=0xFFFF, pc_plus4=0x0040_0004.
   - Downstream signExtend gives 0xFFFF_FFFF.
2. Hold out_ready=0 and offer 0x20087FFF then 0x20088000 on consecutive cycles:
   - Both accepted.
   - in_ready=0 the following cycle.
   - Outputs hold imm16=0x7FFF.
   - Raise out_ready: 0x7FFF then 0x8000 emerge in order, then in_ready=1.
3. Fill to FULL, assert flush with in_valid=1, inst=0x20084000 -> next cycle:
   - out_valid=0, in_ready=1.
   - 0x4000 is never output.
4. Assert rst_n=0 for one edge while FULL with out_ready=0 -> next cycle:
   - out_valid=0, in_ready=1, imm16=0, pc_plus4=4.
   - (With IFID_STALL_CNT_EN) stall_cnt=0.
5. Stream 8 instructions, in_valid=1 and out_ready=1 every cycle -> one output per cycle, in_ready never drops, order preserved. in_pc=0xFFFF_FFFC gives pc_plus4=0.
6. With IFID_STALL_CNT_EN: hold a valid output with out_ready=0 for 5 cycles -> stall_cnt=5. Preload counter near max -> it saturates at 0xFFFF.
